axi_slave_mem: RTL and testbench

AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

---
 rtl/axi_pkg.sv | 24 ++
 rtl/axi_slave_regfile.sv | 35 +++
 rtl/axi_slave_mem.sv | 192 +++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared response codes and channel FSM state encodings for the single-beat
// AXI slave memory.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_HAVE_AW,
        WR_HAVE_W,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_t;

    function automatic logic [1:0] resp_code(input logic in_range);
        return in_range ? RESP_OKAY : RESP_SLVERR;
    endfunction

endpackage

// File: rtl/axi_slave_regfile.sv
// Word storage: one synchronous write port, one combinational read port that
// the caller registers, and an asynchronous clear of every word.
module axi_slave_regfile #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the clear-on-reset forces this storage into flops; a RAM macro
    // cannot reset its contents, so keep DEPTH small or drop the clear.
    // NOTE: state is updated with <= so every reader in the same edge sees the
    // pre-edge value; this is what makes a same-edge read return old data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axi_slave_mem.sv
// Single-beat AXI slave in front of a small word memory; the write and read
// channels run independent FSMs and share only the storage.
module axi_slave_mem
    import axi_pkg::*;
#(
    parameter int BUS_WIDTH  = 32,
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [ID_WIDTH-1:0]   AWID,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [BUS_WIDTH-1:0]  WDATA,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [ID_WIDTH-1:0]   BID,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    input  logic [ID_WIDTH-1:0]   ARID,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [ID_WIDTH-1:0]   RID,
    output logic [BUS_WIDTH-1:0]  RDATA,
    output logic [1:0]            RRESP,
    output logic                  RVALID,
    input  logic                  RREADY
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] addr);
        return (addr >> (IDX_W + 2)) == '0;
    endfunction

    // Holds READYs low through reset and rises on the first edge after release.
    logic out_of_reset;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) out_of_reset <= 1'b0;
        else        out_of_reset <= 1'b1;
    end

    // ---------------- write channel ----------------
    wr_state_t             wr_state, wr_next;
    logic [ID_WIDTH-1:0]   aw_id_q;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [BUS_WIDTH-1:0]  w_data_q;
    logic                  aw_hs, w_hs, wr_commit, wr_ok;
    logic [ID_WIDTH-1:0]   wr_id;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [BUS_WIDTH-1:0]  wr_data;

    assign AWREADY = out_of_reset && (wr_state == WR_IDLE || wr_state == WR_HAVE_W);
    assign WREADY  = out_of_reset && (wr_state == WR_IDLE || wr_state == WR_HAVE_AW);
    assign aw_hs   = AWVALID && AWREADY;
    assign w_hs    = WVALID && WREADY;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) wr_state <= WR_IDLE;
        else        wr_state <= wr_next;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        wr_next   = wr_state;
        wr_commit = 1'b0;
        wr_id     = aw_id_q;
        wr_addr   = aw_addr_q;
        wr_data   = w_data_q;
        case (wr_state)
            WR_IDLE: begin
                if (aw_hs && w_hs) begin
                    wr_commit = 1'b1;
                    wr_id     = AWID;
                    wr_addr   = AWADDR;
                    wr_data   = WDATA;
                    wr_next   = WR_RESP;
                end else if (aw_hs) begin
                    wr_next = WR_HAVE_AW;
                end else if (w_hs) begin
                    wr_next = WR_HAVE_W;
                end
            end
            WR_HAVE_AW: begin
                if (w_hs) begin
                    wr_commit = 1'b1;
                    wr_data   = WDATA;
                    wr_next   = WR_RESP;
                end
            end
            WR_HAVE_W: begin
                if (aw_hs) begin
                    wr_commit = 1'b1;
                    wr_id     = AWID;
                    wr_addr   = AWADDR;
                    wr_next   = WR_RESP;
                end
            end
            WR_RESP: begin
                if (BREADY) wr_next = WR_IDLE;
            end
            default: wr_next = WR_IDLE;
        endcase
    end

    assign wr_ok = addr_ok(wr_addr);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_id_q   <= '0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            BVALID    <= 1'b0;
            BID       <= '0;
            BRESP     <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_id_q   <= AWID;
                aw_addr_q <= AWADDR;
            end
            if (w_hs) w_data_q <= WDATA;
            if (wr_commit) begin
                BVALID <= 1'b1;
                BID    <= wr_id;
                BRESP  <= resp_code(wr_ok);
            end else if (wr_state == WR_RESP && BREADY) begin
                BVALID <= 1'b0;
            end
        end
    end

    // ---------------- read channel ----------------
    rd_state_t            rd_state, rd_next;
    logic                 ar_hs, rd_ok;
    logic [BUS_WIDTH-1:0] mem_rdata;

    assign ARREADY = out_of_reset && (rd_state == RD_IDLE);
    assign ar_hs   = ARVALID && ARREADY;
    assign rd_ok   = addr_ok(ARADDR);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) rd_state <= RD_IDLE;
        else        rd_state <= rd_next;
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE: if (ar_hs)  rd_next = RD_RESP;
            RD_RESP: if (RREADY) rd_next = RD_IDLE;
            default: rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            RVALID <= 1'b0;
            RID    <= '0;
            RDATA  <= '0;
            RRESP  <= RESP_OKAY;
        end else if (ar_hs) begin
            RVALID <= 1'b1;
            RID    <= ARID;
            RDATA  <= rd_ok ? mem_rdata : '0;
            RRESP  <= resp_code(rd_ok);
        end else if (rd_state == RD_RESP && RREADY) begin
            RVALID <= 1'b0;
        end
    end

    axi_slave_regfile #(
        .WIDTH(BUS_WIDTH),
        .DEPTH(MEM_DEPTH),
        .IDX_W(IDX_W)
    ) u_regfile (
        .clk  (ACLK),
        .rst  (ARESET),
        .we   (wr_commit && wr_ok),
        .waddr(wr_addr[IDX_W+1:2]),
        .wdata(wr_data),
        .raddr(ARADDR[IDX_W+1:2]),
        .rdata(mem_rdata)
    );

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: stimulus pushes expected B/R responses
// into queues and a negedge monitor pops and compares on each handshake.
module tb_axi_slave_mem;
    import axi_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [3:0]  AWID = '0;
    logic [31:0] AWADDR = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b1;
    logic [3:0]  ARID = '0;
    logic [31:0] ARADDR = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY = 1'b1;

    axi_slave_mem dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } b_exp_t;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
    } r_exp_t;

    b_exp_t      exp_b[$];
    r_exp_t      exp_r[$];
    logic [31:0] exp_mem [16];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Scoreboard monitor: compares each completed B/R handshake in order.
    always @(negedge ACLK) begin
        b_exp_t be;
        r_exp_t re;
        if (!ARESET && BVALID && BREADY) begin
            if (exp_b.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL b_unexpected: got BID=0x%0h BRESP=0x%0h, expected no response", BID, BRESP);
            end else begin
                be = exp_b.pop_front();
                check("bid", BID, be.id);
                check("bresp", BRESP, be.resp);
            end
        end
        if (!ARESET && RVALID && RREADY) begin
            if (exp_r.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL r_unexpected: got RID=0x%0h RDATA=0x%0h, expected no response", RID, RDATA);
            end else begin
                re = exp_r.pop_front();
                check("rid", RID, re.id);
                check("rdata", RDATA, re.data);
                check("rresp", RRESP, re.resp);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((BVALID || RVALID) && n < 20) begin
            tick();
            n++;
        end
        check("resp_drain_timeout", n < 20, 1);
    endtask

    task automatic write_both(input logic [3:0] id, input logic [31:0] addr,
                              input logic [31:0] data, input logic [1:0] resp);
        int n = 0;
        exp_b.push_back('{id: id, resp: resp});
        AWID = id; AWADDR = addr; AWVALID = 1'b1;
        WDATA = data; WVALID = 1'b1;
        while (!(AWREADY && WREADY) && n < 20) begin
            tick();
            n++;
        end
        check("aw_w_ready_timeout", n < 20, 1);
        tick();
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        check("bvalid_next", BVALID, 1);
        if (resp == RESP_OKAY) exp_mem[addr[5:2]] = data;
    endtask

    task automatic read(input logic [3:0] id, input logic [31:0] addr,
                        input logic [31:0] data, input logic [1:0] resp);
        int n = 0;
        exp_r.push_back('{id: id, data: data, resp: resp});
        ARID = id; ARADDR = addr; ARVALID = 1'b1;
        while (!ARREADY && n < 20) begin
            tick();
            n++;
        end
        check("ar_ready_timeout", n < 20, 1);
        tick();
        ARVALID = 1'b0;
        check("rvalid_next", RVALID, 1);
        wait_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        for (int i = 0; i < 16; i++) exp_mem[i] = '0;

        // Reset: every handshake and response output is low.
        tick();
        tick();
        check("reset_ctrl", {AWREADY, WREADY, ARREADY, BVALID, RVALID, BID, BRESP, RID, RRESP}, 0);
        check("reset_rdata", RDATA, 0);
        ARESET = 1'b0;
        tick();
        check("ready_after_reset", {AWREADY, WREADY, ARREADY}, 3'b111);

        // Simultaneous AW/W, then read back.
        write_both(4'd3, 32'h08, 32'h1234_5678, RESP_OKAY);
        wait_idle();
        read(4'd5, 32'h08, 32'h1234_5678, RESP_OKAY);

        // W two cycles ahead of AW.
        exp_b.push_back('{id: 4'd1, resp: RESP_OKAY});
        WDATA = 32'hCAFE_F00D; WVALID = 1'b1;
        check("wready_idle", WREADY, 1);
        tick();
        WVALID = 1'b0;
        check("wready_after_w", WREADY, 0);
        check("awready_have_w", AWREADY, 1);
        check("bvalid_before_aw", BVALID, 0);
        tick();
        AWID = 4'd1; AWADDR = 32'h0C; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        check("bvalid_after_aw", BVALID, 1);
        exp_mem[3] = 32'hCAFE_F00D;
        wait_idle();
        read(4'd2, 32'h0C, 32'hCAFE_F00D, RESP_OKAY);

        // B back-pressure for three cycles.
        BREADY = 1'b0;
        write_both(4'd6, 32'h04, 32'h0BAD_BEEF, RESP_OKAY);
        for (int i = 0; i < 3; i++) begin
            check("bvalid_stall", BVALID, 1);
            check("bid_stall", BID, 4'd6);
            check("bresp_stall", BRESP, RESP_OKAY);
            check("aw_w_ready_stall", {AWREADY, WREADY}, 2'b00);
            tick();
        end
        BREADY = 1'b1;
        check("aw_w_ready_return", {AWREADY, WREADY}, 2'b00);
        tick();
        check("bvalid_cleared", BVALID, 0);
        check("aw_w_ready_idle", {AWREADY, WREADY}, 2'b11);

        // Out-of-range write and read, then every word is unchanged.
        write_both(4'd4, 32'h40, 32'hFFFF_FFFF, RESP_SLVERR);
        wait_idle();
        read(4'd4, 32'h40, 32'h0, RESP_SLVERR);
        for (int i = 0; i < 16; i++) begin
            logic [31:0] a;
            a = i * 4;
            read(4'(i), a, exp_mem[i], RESP_OKAY);
        end

        // Same-edge write and read of word 2 return the old data.
        write_both(4'd7, 32'h08, 32'hAAAA_AAAA, RESP_OKAY);
        wait_idle();
        exp_b.push_back('{id: 4'd7, resp: RESP_OKAY});
        exp_r.push_back('{id: 4'd8, data: 32'hAAAA_AAAA, resp: RESP_OKAY});
        AWID = 4'd7; AWADDR = 32'h08; AWVALID = 1'b1;
        WDATA = 32'h1111_1111; WVALID = 1'b1;
        ARID = 4'd8; ARADDR = 32'h08; ARVALID = 1'b1;
        check("all_ready", {AWREADY, WREADY, ARREADY}, 3'b111);
        tick();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        exp_mem[2] = 32'h1111_1111;
        wait_idle();
        read(4'd9, 32'h08, 32'h1111_1111, RESP_OKAY);

        // Reset with both responses pending.
        BREADY = 1'b0; RREADY = 1'b0;
        AWID = 4'd2; AWADDR = 32'h0C; AWVALID = 1'b1;
        WDATA = 32'h5555_5555; WVALID = 1'b1;
        ARID = 4'd3; ARADDR = 32'h0C; ARVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        check("pending_valids", {BVALID, RVALID}, 2'b11);
        #2 ARESET = 1'b1;
        #1;
        check("reset_drops_valids", {BVALID, RVALID}, 2'b00);
        check("reset_drops_readies", {AWREADY, WREADY, ARREADY}, 3'b000);
        BREADY = 1'b1; RREADY = 1'b1;
        tick();
        tick();
        ARESET = 1'b0;
        check("readies_before_edge", {AWREADY, WREADY, ARREADY}, 3'b000);
        tick();
        check("readies_after_release", {AWREADY, WREADY, ARREADY}, 3'b111);
        for (int i = 0; i < 16; i++) exp_mem[i] = '0;
        read(4'hA, 32'h04, 32'h0, RESP_OKAY);
        read(4'hB, 32'h08, 32'h0, RESP_OKAY);
        read(4'hC, 32'h0C, 32'h0, RESP_OKAY);

        n = 0;
        while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 20) begin
            tick();
            n++;
        end
        check("b_queue_drained", exp_b.size(), 0);
        check("r_queue_drained", exp_r.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
